// File: rtl/race_pkg.sv
// race_pkg: shared types, constants and helpers for the race game enemy logic.
//   game_state_t  : game FSM encoding (IDLE, RUN, CRASH)
//   LANE_*_X      : screen x position of each lane
//   SPAWN_Y0      : enemy start row
//   lfsr_step     : one step of the x^4+x^3+1 lane LFSR
//   lane_x        : lane index to x position
//   pick_lane     : lane choice from LFSR state, never repeating the last lane
package race_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2
  } game_state_t;

  localparam logic [9:0] LANE_LEFT_X   = 10'd197;
  localparam logic [9:0] LANE_CENTER_X = 10'd279;
  localparam logic [9:0] LANE_RIGHT_X  = 10'd361;
  localparam logic [9:0] SPAWN_Y0      = 10'd0;

  localparam logic [3:0] LFSR_SEED   = 4'b1001;
  localparam logic [1:0] LANE_CENTER = 2'd1;
  localparam logic [3:0] LEVEL_MAX   = 4'd15;

  // Fibonacci form: taps at bit positions 4 and 3 of the polynomial.
  function automatic logic [3:0] lfsr_step(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  function automatic logic [9:0] lane_x(input logic [1:0] lane);
    logic [9:0] x;
    case (lane)
      2'd0:    x = LANE_LEFT_X;
      2'd2:    x = LANE_RIGHT_X;
      default: x = LANE_CENTER_X;
    endcase
    return x;
  endfunction

  // Only three lanes exist, so the unused code 3 folds onto the centre lane.
  function automatic logic [1:0] pick_lane(input logic [3:0] lfsr, input logic [1:0] last);
    logic [1:0] r;
    r = lfsr[1:0];
    if (r == 2'd3) r = 2'd1;
    if (r == last) r = (r == 2'd2) ? 2'd0 : r + 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/lane_lfsr.sv
// lane_lfsr: 4-bit maximal-length LFSR supplying lane randomness.
//   i_clk50mhz : system clock
//   i_reset    : synchronous active-high reset, loads the seed
//   i_advance  : step the register this cycle
//   o_state    : current LFSR state
module lane_lfsr
  import race_pkg::*;
(
  input  logic       i_clk50mhz,
  input  logic       i_reset,
  input  logic       i_advance,
  output logic [3:0] o_state
);

  logic [3:0] r_state;

  always_ff @(posedge i_clk50mhz) begin
    if (i_reset) begin
      r_state <= LFSR_SEED;
    end else if (i_advance) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler: game-state FSM, enemy launch sequencing and difficulty ramp.
//   i_clk50mhz    : system clock
//   i_reset       : synchronous active-high reset
//   i_tick        : one-cycle spawn-tick strobe
//   i_start       : starts a game from IDLE
//   i_collision   : collision flag, moves RUN to CRASH
//   i_slot_done   : per-slot pulse, that enemy has left the screen
//   o_spawn_valid : one-hot launch pulse
//   o_spawn_x     : lane x for the launching slot, held between launches
//   o_spawn_y     : start row (constant)
//   o_accel       : descent-divider acceleration
//   o_level       : difficulty level, saturating
//   o_game_state  : 0 IDLE, 1 RUN, 2 CRASH
module enemy_spawn_scheduler
  import race_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 2,
  parameter int unsigned SPAWN_GAP   = 14,
  parameter int unsigned LEVEL_TICKS = 50,
  parameter int unsigned ACCEL_STEP  = 1000,
  parameter int unsigned ACCEL_MAX   = 100000
) (
  input  logic                 i_clk50mhz,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_start,
  input  logic                 i_collision,
  input  logic [NUM_SLOTS-1:0] i_slot_done,
  output logic [NUM_SLOTS-1:0] o_spawn_valid,
  output logic [9:0]           o_spawn_x,
  output logic [9:0]           o_spawn_y,
  output logic [24:0]          o_accel,
  output logic [3:0]           o_level,
  output logic [1:0]           o_game_state
);

  localparam int unsigned GAP_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int unsigned LVL_W = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;

  game_state_t          r_state;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [LVL_W-1:0]     r_lvl_cnt;
  logic                 r_pending;
  logic [NUM_SLOTS-1:0] r_busy;
  logic [NUM_SLOTS-1:0] r_spawn_valid;
  logic [9:0]           r_spawn_x;
  logic [1:0]           r_last_lane;
  logic [24:0]          r_accel;
  logic [3:0]           r_level;

  logic [3:0]           w_lfsr;
  logic [3:0]           w_lfsr_look;
  logic                 w_run_tick;
  logic                 w_gap_done;
  logic                 w_lvl_wrap;
  logic                 w_launch;
  logic [NUM_SLOTS-1:0] w_free_oh;
  logic                 w_any_free;
  logic [1:0]           w_lane;
  logic [25:0]          w_accel_sum;
  logic [24:0]          w_accel_next;

  lane_lfsr u_lane_lfsr (
    .i_clk50mhz (i_clk50mhz),
    .i_reset    (i_reset),
    .i_advance  (i_tick),
    .o_state    (w_lfsr)
  );

  // Lowest-index free slot; busy bits released this cycle count only from the next one.
  always_comb begin
    w_free_oh  = '0;
    w_any_free = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!r_busy[i] && !w_any_free) begin
        w_free_oh[i] = 1'b1;
        w_any_free   = 1'b1;
      end
    end
  end

  always_comb begin
    // Collision wins: a colliding cycle neither counts ticks nor launches.
    w_run_tick = (r_state == RUN) && i_tick && !i_collision;
    w_gap_done = w_run_tick && (r_gap_cnt == GAP_W'(SPAWN_GAP - 1));
    w_lvl_wrap = w_run_tick && (r_lvl_cnt == LVL_W'(LEVEL_TICKS - 1));
    w_launch   = (r_state == RUN) && !i_collision && (r_pending || w_gap_done) && w_any_free;
    // A tick-driven launch uses the state the LFSR steps to on this same edge.
    w_lfsr_look  = i_tick ? lfsr_step(w_lfsr) : w_lfsr;
    w_lane       = pick_lane(w_lfsr_look, r_last_lane);
    w_accel_sum  = {1'b0, r_accel} + 26'(ACCEL_STEP);
    w_accel_next = (w_accel_sum > 26'(ACCEL_MAX)) ? 25'(ACCEL_MAX) : w_accel_sum[24:0];
  end

  always_ff @(posedge i_clk50mhz) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_gap_cnt     <= '0;
      r_lvl_cnt     <= '0;
      r_pending     <= 1'b0;
      r_busy        <= '0;
      r_spawn_valid <= '0;
      r_spawn_x     <= LANE_CENTER_X;
      r_last_lane   <= LANE_CENTER;
      r_accel       <= '0;
      r_level       <= '0;
    end else begin
      r_spawn_valid <= '0;
      r_busy        <= (r_busy & ~i_slot_done) | (w_launch ? w_free_oh : '0);
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state   <= RUN;
            // Preloaded so the first RUN tick completes a gap immediately.
            r_gap_cnt <= GAP_W'(SPAWN_GAP - 1);
            r_lvl_cnt <= '0;
          end
        end
        RUN: begin
          if (i_collision) begin
            r_state   <= CRASH;
            r_pending <= 1'b0;
          end else begin
            if (w_run_tick) begin
              r_gap_cnt <= w_gap_done ? '0 : r_gap_cnt + GAP_W'(1);
              r_lvl_cnt <= w_lvl_wrap ? '0 : r_lvl_cnt + LVL_W'(1);
            end
            if (w_lvl_wrap) begin
              r_level <= (r_level == LEVEL_MAX) ? r_level : r_level + 4'd1;
              r_accel <= w_accel_next;
            end
            if (w_launch) begin
              r_spawn_valid <= w_free_oh;
              r_spawn_x     <= lane_x(w_lane);
              r_last_lane   <= w_lane;
              // A stalled request and a fresh gap together leave one request behind.
              r_pending     <= r_pending & w_gap_done;
            end else begin
              r_pending <= r_pending | w_gap_done;
            end
          end
        end
        CRASH: begin
          r_pending <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_spawn_valid = r_spawn_valid;
  assign o_spawn_x     = r_spawn_x;
  assign o_spawn_y     = SPAWN_Y0;
  assign o_accel       = r_accel;
  assign o_level       = r_level;
  assign o_game_state  = r_state;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// tb_enemy_spawn_scheduler: directed scenarios plus randomized play, checked every cycle
// against a behavioural model built from total RUN tick counts and a lane table.
module tb_enemy_spawn_scheduler;

  localparam int NS    = 2;
  localparam int GAP   = 14;
  localparam int LT    = 50;
  localparam int STEP  = 1000;
  localparam int AMAX  = 100000;

  logic          clk;
  logic          reset;
  logic          tick;
  logic          start;
  logic          collision;
  logic [NS-1:0] slot_done;
  logic [NS-1:0] spawn_valid;
  logic [9:0]    spawn_x;
  logic [9:0]    spawn_y;
  logic [24:0]   accel;
  logic [3:0]    level;
  logic [1:0]    game_state;

  enemy_spawn_scheduler #(
    .NUM_SLOTS   (NS),
    .SPAWN_GAP   (GAP),
    .LEVEL_TICKS (LT),
    .ACCEL_STEP  (STEP),
    .ACCEL_MAX   (AMAX)
  ) dut (
    .i_clk50mhz    (clk),
    .i_reset       (reset),
    .i_tick        (tick),
    .i_start       (start),
    .i_collision   (collision),
    .i_slot_done   (slot_done),
    .o_spawn_valid (spawn_valid),
    .o_spawn_x     (spawn_x),
    .o_spawn_y     (spawn_y),
    .o_accel       (accel),
    .o_level       (level),
    .o_game_state  (game_state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, act, exp);
    end
  endtask

  // Reference model state.
  int      m_state;
  int      m_lfsr;
  int      m_req;
  int      m_run_ticks;
  int      m_level;
  int      m_accel;
  int      m_last;
  int      m_x;
  bit [NS-1:0] m_busy;
  bit [NS-1:0] m_valid;
  int      lane_tab[3] = '{197, 279, 361};

  // Enemy lifetimes for automatic slot_done generation.
  int      life[NS];
  bit      auto_done;

  function automatic int lfsr_next(input int s);
    int fb;
    fb = ((s >> 3) ^ (s >> 2)) & 1;
    return ((s << 1) | fb) & 15;
  endfunction

  task automatic model_reset();
    m_state = 0; m_lfsr = 9; m_req = 0; m_run_ticks = 0; m_level = 0; m_accel = 0;
    m_last = 1; m_x = 279; m_busy = '0; m_valid = '0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit c, input bit r,
                            input bit [NS-1:0] d);
    int look, gap, total, free, lane;
    if (r) begin
      model_reset();
      return;
    end
    look = t ? lfsr_next(m_lfsr) : m_lfsr;
    m_valid = '0;
    if (m_state == 0) begin
      if (s) begin
        m_state = 1;
        m_run_ticks = 0;
        m_req = 0;
      end
    end else if (m_state == 1) begin
      if (c) begin
        m_state = 2;
        m_req = 0;
      end else begin
        gap = 0;
        if (t) begin
          m_run_ticks++;
          // A launch request on the first RUN tick and every GAP ticks after it.
          if ((m_run_ticks - 1) % GAP == 0) gap = 1;
          if (m_run_ticks % LT == 0) begin
            m_level = (m_level < 15) ? m_level + 1 : 15;
            m_accel = (m_accel + STEP > AMAX) ? AMAX : m_accel + STEP;
          end
        end
        total = m_req + gap;
        free = -1;
        for (int i = 0; i < NS; i++) if (!m_busy[i] && free < 0) free = i;
        if (total > 0 && free >= 0) begin
          lane = look & 3;
          if (lane == 3) lane = 1;
          if (lane == m_last) lane = (lane + 1) % 3;
          m_last = lane;
          m_x = lane_tab[lane];
          m_valid[free] = 1'b1;
          total--;
        end
        m_req = (total > 1) ? 1 : total;
      end
    end
    m_busy = (m_busy & ~d) | m_valid;
    m_lfsr = look;
  endtask

  // One clock cycle: drive inputs, step the model, compare after the edge.
  task automatic cyc(input bit t, input bit s, input bit c, input bit r, input bit [NS-1:0] d);
    bit [NS-1:0] dd;
    dd = d;
    if (auto_done) begin
      for (int i = 0; i < NS; i++) begin
        if (life[i] == 1) begin
          dd[i] = 1'b1;
          life[i] = 0;
        end else if (life[i] > 1) begin
          life[i]--;
        end
      end
    end
    tick = t; start = s; collision = c; reset = r; slot_done = dd;
    model_step(t, s, c, r, dd);
    @(posedge clk);
    #1;
    check_eq("valid", spawn_valid, m_valid);
    check_eq("x", spawn_x, m_x);
    check_eq("y", spawn_y, 0);
    check_eq("accel", accel, m_accel);
    check_eq("level", level, m_level);
    check_eq("state", game_state, m_state);
    if (r) begin
      for (int i = 0; i < NS; i++) life[i] = 0;
    end else begin
      for (int i = 0; i < NS; i++) if (spawn_valid[i]) life[i] = $urandom_range(2, 25);
    end
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, guard, saved_accel, pulses;
    bit found;
    tick = 0; start = 0; collision = 0; reset = 1; slot_done = '0;
    auto_done = 1'b0;
    for (int i = 0; i < NS; i++) life[i] = 0;
    model_reset();

    // Reset values.
    cyc(0, 0, 0, 1, '0);
    cyc(0, 0, 0, 1, '0);
    check_eq("rst_state", game_state, 0);
    check_eq("rst_x", spawn_x, 279);
    check_eq("rst_accel", accel, 0);
    check_eq("rst_level", level, 0);

    // Start and first launch: seed 1001 steps to 0011, lane 3->1, repeats last, so lane 2.
    cyc(0, 1, 0, 0, '0);
    check_eq("run_state", game_state, 1);
    cyc(1, 0, 0, 0, '0);
    check_eq("first_valid", spawn_valid, 1);
    check_eq("first_x", spawn_x, 361);
    x0 = spawn_x;

    // Second launch after 14 more ticks goes to slot 1 in a different lane.
    for (int i = 0; i < 13; i++) cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    check_eq("second_valid", spawn_valid, 2);
    check_eq("lane_diff", (spawn_x != x0), 1);

    // Full stall, then release of slot 0 launches two cycles later without a tick.
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, '0);
    check_eq("stall_valid", spawn_valid, 0);
    cyc(0, 0, 0, 0, 2'b01);
    check_eq("release_wait", spawn_valid, 0);
    cyc(0, 0, 0, 0, '0);
    check_eq("release_valid", spawn_valid, 1);

    // Ramp to level 1, then far past the acceleration ceiling.
    auto_done = 1'b1;
    guard = 0;
    while (m_run_ticks < LT && guard < 2000) begin
      cyc(1'($urandom_range(0, 3) != 0), 0, 0, 0, '0);
      guard++;
    end
    check_eq("lvl1_level", level, 1);
    check_eq("lvl1_accel", accel, 1000);
    guard = 0;
    while (m_run_ticks < 101 * LT && guard < 20000) begin
      cyc(1'($urandom_range(0, 3) != 0), 0, 0, 0, '0);
      guard++;
    end
    check_eq("clamp_accel", accel, 100000);
    check_eq("clamp_level", level, 15);

    // Collision in the very cycle a launch would fire.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_busy != '1 && (m_req == 1 || m_run_ticks % GAP == 0)) begin
        cyc(1, 0, 1, 0, '0);
        found = 1'b1;
      end else begin
        cyc(1, 0, 0, 0, '0);
      end
    end
    check_eq("coll_found", found, 1);
    check_eq("coll_state", game_state, 2);
    check_eq("coll_valid", spawn_valid, 0);
    saved_accel = accel;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1, 0, 0, 0, '0);
      if (spawn_valid != '0) pulses++;
    end
    check_eq("crash_pulses", pulses, 0);
    check_eq("crash_accel", accel, saved_accel);

    // Reset mid-game with a launch pending.
    auto_done = 1'b0;
    cyc(0, 0, 0, 1, '0);
    cyc(0, 1, 0, 0, '0);
    guard = 0;
    while (m_req == 0 && guard < 100) begin
      cyc(1, 0, 0, 0, '0);
      guard++;
    end
    check_eq("pend_seen", m_req, 1);
    cyc(1, 1, 0, 1, '0);
    check_eq("mid_state", game_state, 0);
    check_eq("mid_valid", spawn_valid, 0);
    check_eq("mid_x", spawn_x, 279);
    check_eq("mid_accel", accel, 0);
    check_eq("mid_level", level, 0);
    cyc(0, 1, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    check_eq("restart_valid", spawn_valid, 1);

    // Randomized play across several games.
    auto_done = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 399) == 0), '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_spawn_scheduler.md
# enemy_spawn_scheduler

Sequences the enemy cars of the race game. Holds the game-state FSM (idle, run, crash) and decides when and in which lane each enemy slot is launched. Also owns the difficulty ramp, the acceleration value fed to the enemy-descent clock divider. Sits between the spawn/tick dividers, the collision ALU and the Enemy instances; it replaces the ad-hoc counter logic at the top level.

## Interface
- `NUM_SLOTS`, default 2: number of Enemy instances managed.
- `SPAWN_GAP`, default 14: ticks between consecutive launches.
- `LEVEL_TICKS`, default 50: ticks per difficulty level.
- `ACCEL_STEP`, default 1000: acceleration increment per level.
- `ACCEL_MAX`, default 100000 (25'h186a0): acceleration ceiling.
- `clk50mhz`  in  1: single system clock; every register in this block is clocked on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `tick`  in  1: one-cycle spawn-tick strobe, synchronous to `clk50mhz`.
- `start`  in  1: level input (left|right); starts a game from IDLE.
- `collision`  in  1: level input from the collision ALU.
- `slot_done`  in  NUM_SLOTS: one-cycle pulse per slot; that enemy has left the screen.
- `spawn_valid`  out  NUM_SLOTS: one-hot, one-cycle launch pulse.
- `spawn_x`  out  10: lane x position for the launching slot.
- `spawn_y`  out  10: start y position, always 0.
- `accel`  out  25: descent-divider acceleration.
- `level`  out  4: current difficulty level, saturating at 15.
- `game_state`  out  2: 0 = IDLE, 1 = RUN, 2 = CRASH.

## Operation
- **FSM**
  - IDLE → RUN when `start` = 1.
  - RUN → CRASH when `collision` = 1.
  - CRASH exits only on `reset`.
  - `reset` forces IDLE from any state and clears all counters and busy bits.
- **LFSR**
  - 4-bit, polynomial x^4+x^3+1, seed 4'b1001.
  - Advances on every `tick` in every state, so idle time seeds the randomness.
- **Lane pick**
  - r = lfsr[1:0]; r = 3 maps to 1.
  - If r equals the previously launched lane, use (r+1) mod 3 instead. Consecutive launches therefore never share a lane.
  - Lane x values: 0 → 197, 1 → 279, 2 → 361.
- **Gap counter**
  - Counts ticks in RUN only.
  - When it reaches SPAWN_GAP-1 it wraps to 0 and sets `pending`.
- **Launch**
  - While `pending`=1 and any busy bit is 0, launch the lowest-index free slot: pulse `spawn_valid[i]`, drive `spawn_x`, set busy[i], clear `pending`.
  - If all slots are busy, `pending` holds and the launch fires on the first cycle a slot is free. No new tick is needed.
  - The first launch after entering RUN happens on the first tick.
- **Slot release**
  - `slot_done[i]` clears busy[i].
  - Same cycle as a launch decision: the freed slot is considered from the next cycle.
- **Difficulty ramp**
  - A level counter counts RUN ticks. At LEVEL_TICKS-1 it wraps.
  - On wrap: `level` +1 (saturating at 15) and accel = min(accel + ACCEL_STEP, ACCEL_MAX).
- **CRASH**
  - No launches; `pending` is cleared.
  - `accel` and `level` are frozen.
  - The LFSR keeps running.

## Timing
- Reset values:
  - `game_state` = 0, `spawn_valid` = 0.
  - `spawn_x` = 279, `spawn_y` = 0, `accel` = 0, `level` = 0.
  - busy = 0, `pending` = 0, last lane = 1, lfsr = 4'b1001.
- All outputs are registered.
- Latency: the tick that completes a gap produces `spawn_valid` one cycle later, provided a slot is free.
- `spawn_x` is valid only in the `spawn_valid` cycle and holds its value afterwards.
- `collision` and a launch decision in the same cycle: collision wins and no pulse is issued.
- `reset` asserted in the same cycle as `tick` or `start`: reset wins.
- Acceleration arithmetic is done at 26 bits before the clamp; there is no wrap-around.

## Structure
- Package `race_pkg`:
  - state encoding `game_state_t` (IDLE, RUN, CRASH);
  - lane constants LANE_LEFT_X = 197, LANE_CENTER_X = 279, LANE_RIGHT_X = 361;
  - SPAWN_Y0 = 0.
- Sub-module `lane_lfsr`: 4-bit LFSR with `clk50mhz`, `reset`, advance enable and a 4-bit state output.
- FSM, counters, slot allocator and ramp stay in the top of this block.

## Test plan
- **Start and first launch:** reset, `start`=1, then one `tick` → `game_state`=1; `spawn_valid`=2'b01 one cycle after the tick; `spawn_x` equals the lane mapped from lfsr state 4'b1001 advanced once.
- **Gap and slot allocation:** 14 further ticks with slot 0 still busy → `spawn_valid`=2'b10, and the lane differs from the first launch.
- **Full stall:** both slots busy and the gap completes → no pulse. Then `slot_done[0]` → `spawn_valid`=2'b01 two cycles later, with no tick required.
- **Ramp and clamp:** 50 RUN ticks → `level`=1, `accel`=1000. Continue for 100 levels' worth of ticks → `accel` is clamped at 100000 and `level` is held at 15.
- **Collision priority:** `collision`=1 in the same cycle the launch would fire → `game_state`=2, no pulse. Further ticks produce no launches and leave `accel` unchanged.
- **Reset mid-game:** reset while in RUN with a launch pending → all outputs return to their reset values next cycle; the next `start` plus tick launches slot 0.
